// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared types and default widths for the slave-side Ax arbitration stage.
package sa_pkg;

  typedef enum logic [0:0] {
    SA_ARB  = 1'b0,
    SA_HOLD = 1'b1
  } sa_state_e;

  localparam int SA_MST_AMT        = 2;
  localparam int SA_TRANS_MST_ID_W = 5;
  localparam int SA_MST_ID_W       = $clog2(SA_MST_AMT);
  localparam int SA_TRANS_SLV_ID_W = SA_TRANS_MST_ID_W + SA_MST_ID_W;
  localparam int SA_ADDR_W         = 32;
  localparam int SA_BURST_W        = 2;
  localparam int SA_LEN_W          = 3;
  localparam int SA_SIZE_W         = 3;
  localparam int SA_AX_PAYLOAD_W   = SA_TRANS_SLV_ID_W + SA_ADDR_W + SA_BURST_W + SA_LEN_W + SA_SIZE_W;

  // Round-robin successor; written without % so non-power-of-2 counts synthesize cheaply.
  function automatic int sa_wrap_inc(input int idx, input int amt);
    return (idx + 1 >= amt) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sa_rr_arbiter.sv
// rtl/sa_rr_arbiter.sv - round-robin pick: first requester at or after the pointer, wrapping.
module sa_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          gnt_valid_o,
  output logic [IW-1:0] gnt_idx_o
);

  // Scan from the far end so the candidate closest to the pointer is written last.
  always_comb begin
    int idx;
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      if (req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/sa_ax_arbiter.sv
// rtl/sa_ax_arbiter.sv - merges per-master Ax requests onto one slave Ax port and logs grant order.
// Define SA_AX_OUTPUT_REG_EN to register the slave Ax port through a full skid buffer.
module sa_ax_arbiter
  import sa_pkg::*;
#(
  parameter int MST_AMT           = 2,
  parameter int OUTSTANDING_AMT   = 8,
  parameter int OUTST_CTN_W       = $clog2(OUTSTANDING_AMT) + 1,
  parameter int ADDR_WIDTH        = 32,
  parameter int TRANS_MST_ID_W    = 5,
  parameter int TRANS_BURST_W     = 2,
  parameter int TRANS_DATA_LEN_W  = 3,
  parameter int TRANS_DATA_SIZE_W = 3,
  parameter int MST_ID_W          = $clog2(MST_AMT),
  parameter int TRANS_SLV_ID_W    = TRANS_MST_ID_W + MST_ID_W
) (
  input  logic                                  ACLK_i,
  input  logic                                  ARESET_i,
  input  logic [TRANS_MST_ID_W*MST_AMT-1:0]     m_AxID_i,
  input  logic [ADDR_WIDTH*MST_AMT-1:0]         m_AxADDR_i,
  input  logic [TRANS_BURST_W*MST_AMT-1:0]      m_AxBURST_i,
  input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]   m_AxLEN_i,
  input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]  m_AxSIZE_i,
  input  logic [MST_AMT-1:0]                    m_AxVALID_i,
  output logic [MST_AMT-1:0]                    m_AxREADY_o,
  output logic [TRANS_SLV_ID_W-1:0]             s_AxID_o,
  output logic [ADDR_WIDTH-1:0]                 s_AxADDR_o,
  output logic [TRANS_BURST_W-1:0]              s_AxBURST_o,
  output logic [TRANS_DATA_LEN_W-1:0]           s_AxLEN_o,
  output logic [TRANS_DATA_SIZE_W-1:0]          s_AxSIZE_o,
  output logic                                  s_AxVALID_o,
  input  logic                                  s_AxREADY_i,
  input  logic                                  s_xVALID_i,
  input  logic                                  s_xREADY_i,
  output logic [MST_ID_W-1:0]                   sa_xDATA_mst_id_o,
  output logic                                  sa_xDATA_disable_o,
  output logic [OUTST_CTN_W-1:0]                sa_Ax_outst_ctn_o
);

  localparam int PW    = TRANS_SLV_ID_W + ADDR_WIDTH + TRANS_BURST_W + TRANS_DATA_LEN_W + TRANS_DATA_SIZE_W;
  localparam int PTR_W = (OUTSTANDING_AMT > 1) ? $clog2(OUTSTANDING_AMT) : 1;

  sa_state_e                   state_q;
  logic [MST_ID_W-1:0]         rr_ptr_q, hold_idx_q;
  logic                        arb_valid;
  logic [MST_ID_W-1:0]         arb_idx;
  logic                        a_valid, a_ready, a_hs;
  logic [MST_ID_W-1:0]         a_idx;
  logic [TRANS_DATA_LEN_W-1:0] a_len;
  logic [PW-1:0]               a_payload;
  logic                        s_valid;
  logic [PW-1:0]               s_payload;
  logic                        fifo_full, fifo_empty;

  sa_rr_arbiter #(.N(MST_AMT), .IW(MST_ID_W)) u_rr (
    .req_i       (m_AxVALID_i),
    .ptr_i       (rr_ptr_q),
    .gnt_valid_o (arb_valid),
    .gnt_idx_o   (arb_idx)
  );

  // HOLD keeps the latched master on the port and ignores new requests until accepted.
  always_comb begin
    a_valid = arb_valid & ~fifo_full;
    a_idx   = arb_idx;
    if (state_q == SA_HOLD) begin
      a_valid = 1'b1;
      a_idx   = hold_idx_q;
    end
  end

  assign a_hs  = a_valid & a_ready;
  assign a_len = m_AxLEN_i[int'(a_idx)*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
  assign a_payload = {a_idx,
                      m_AxID_i[int'(a_idx)*TRANS_MST_ID_W +: TRANS_MST_ID_W],
                      m_AxADDR_i[int'(a_idx)*ADDR_WIDTH +: ADDR_WIDTH],
                      m_AxBURST_i[int'(a_idx)*TRANS_BURST_W +: TRANS_BURST_W],
                      a_len,
                      m_AxSIZE_i[int'(a_idx)*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W]};

  always_comb begin
    m_AxREADY_o = '0;
    if (a_hs) m_AxREADY_o[a_idx] = 1'b1;
  end

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      state_q    <= SA_ARB;
      rr_ptr_q   <= '0;
      hold_idx_q <= '0;
    end else begin
      case (state_q)
        SA_ARB: begin
          if (a_valid) begin
            if (a_ready) begin
              rr_ptr_q <= MST_ID_W'(sa_wrap_inc(int'(a_idx), MST_AMT));
            end else begin
              hold_idx_q <= a_idx;
              state_q    <= SA_HOLD;
            end
          end
        end
        SA_HOLD: begin
          if (a_ready) begin
            rr_ptr_q <= MST_ID_W'(sa_wrap_inc(int'(hold_idx_q), MST_AMT));
            state_q  <= SA_ARB;
          end
        end
        default: state_q <= SA_ARB;
      endcase
    end
  end

`ifdef SA_AX_OUTPUT_REG_EN
  logic          out_valid_q, skid_valid_q;
  logic [PW-1:0] out_data_q, skid_data_q;

  // Upstream ready depends only on the skid slot, so no combinational path from s_AxREADY_i.
  assign a_ready = ~skid_valid_q;

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q || s_AxREADY_i) begin
      if (skid_valid_q) begin
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q <= a_valid;
      end
    end else if (a_valid && !skid_valid_q) begin
      skid_valid_q <= 1'b1;
    end
  end

  always_ff @(posedge ACLK_i) begin
    if (!out_valid_q || s_AxREADY_i) begin
      out_data_q <= skid_valid_q ? skid_data_q : a_payload;
    end else if (!skid_valid_q) begin
      skid_data_q <= a_payload;
    end
  end

  assign s_valid   = out_valid_q;
  assign s_payload = out_data_q;
`else
  assign a_ready   = s_AxREADY_i;
  assign s_valid   = a_valid;
  assign s_payload = a_payload;
`endif

  assign s_AxVALID_o = s_valid;
  assign {s_AxID_o, s_AxADDR_o, s_AxBURST_o, s_AxLEN_o, s_AxSIZE_o} = s_payload;

  logic [MST_ID_W-1:0]         ord_idx_q [OUTSTANDING_AMT];
  logic [TRANS_DATA_LEN_W-1:0] ord_len_q [OUTSTANDING_AMT];
  logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
  logic [OUTST_CTN_W-1:0]      ctn_q;
  logic [TRANS_DATA_LEN_W-1:0] beat_q;
  logic                        beat, pop;

  assign fifo_full  = (ctn_q == OUTST_CTN_W'(OUTSTANDING_AMT));
  assign fifo_empty = (ctn_q == '0);
  assign beat       = s_xVALID_i & s_xREADY_i & ~fifo_empty;
  assign pop        = beat & (beat_q == ord_len_q[rd_ptr_q]);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING_AMT - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge ACLK_i) begin
    if (a_hs) begin
      ord_idx_q[wr_ptr_q] <= a_idx;
      ord_len_q[wr_ptr_q] <= a_len;
    end
  end

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ctn_q    <= '0;
      beat_q   <= '0;
    end else begin
      if (a_hs) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (beat) beat_q   <= pop ? '0 : beat_q + 1'b1;
      case ({a_hs, pop})
        2'b10:   ctn_q <= ctn_q + 1'b1;
        2'b01:   ctn_q <= ctn_q - 1'b1;
        default: ctn_q <= ctn_q;
      endcase
    end
  end

  assign sa_xDATA_mst_id_o  = ord_idx_q[rd_ptr_q];
  assign sa_xDATA_disable_o = fifo_empty;
  assign sa_Ax_outst_ctn_o  = ctn_q;

endmodule
